// File: rtl/io_timer.sv
// io_timer: prescaled 16-bit down-counter with auto-reload, W1C pending flag and level interrupt on dma_io.
// The 8-bit prescaler is built only when IO_TIMER_PRESCALE_EN is defined; otherwise a tick occurs every enabled cycle.
module io_timer #(
   parameter logic [13:0] BASE = 14'h3C00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_io_we,
   input  logic [15:2] dma_io_wadr,
   input  logic [15:0] dma_io_wdata,
   input  logic [15:2] dma_io_radr,
   input  logic [15:0] dma_io_rdata_in,
   output logic [15:0] dma_io_rdata,
   output logic        interrupt_0
);

   localparam int unsigned DW = 16;
   localparam int unsigned PW = 8;
   localparam int unsigned AW = 14;

   localparam logic [AW-1:0] ADR_CTRL   = BASE;
   localparam logic [AW-1:0] ADR_PRESC  = BASE + AW'(1);
   localparam logic [AW-1:0] ADR_RELOAD = BASE + AW'(2);
   localparam logic [AW-1:0] ADR_COUNT  = BASE + AW'(3);
   localparam logic [AW-1:0] ADR_STATUS = BASE + AW'(4);

   logic          en_q, en_n;
   logic          auto_q, auto_n;
   logic          ie_q, ie_n;
   logic          pend_q, pend_n;
   logic [DW-1:0] reload_q, reload_n;
   logic [DW-1:0] count_q, count_n;
   logic          hit_q;
   logic [DW-1:0] rdata_q;

   logic          wr_ctrl_c;
   logic          wr_reload_c;
   logic          wr_count_c;
   logic          wr_status_c;
   logic          start_c;
   logic          tick_c;
   logic          expire_c;
   logic [PW-1:0] prescale_rd_c;
   logic          rd_hit_c;
   logic [DW-1:0] rd_val_c;

   assign wr_ctrl_c   = dma_io_we && (dma_io_wadr == ADR_CTRL);
   assign wr_reload_c = dma_io_we && (dma_io_wadr == ADR_RELOAD);
   assign wr_count_c  = dma_io_we && (dma_io_wadr == ADR_COUNT);
   assign wr_status_c = dma_io_we && (dma_io_wadr == ADR_STATUS);

   // Only a 0->1 transition of EN (re)starts the count
   assign start_c  = wr_ctrl_c && dma_io_wdata[0] && !en_q;
   assign expire_c = tick_c && (count_q == '0);

`ifdef IO_TIMER_PRESCALE_EN
   logic          wr_presc_c;
   logic [PW-1:0] prescale_q, prescale_n;
   logic [PW-1:0] pcnt_q, pcnt_n;

   assign wr_presc_c    = dma_io_we && (dma_io_wadr == ADR_PRESC);
   assign tick_c        = en_q && (pcnt_q == prescale_q);
   assign prescale_rd_c = prescale_q;

   // Prescale counter wraps to 0 on the tick it produces; restart clears it
   always_comb begin
      prescale_n = prescale_q;
      pcnt_n     = pcnt_q;
      if (en_q) begin
         pcnt_n = tick_c ? '0 : pcnt_q + PW'(1);
      end
      if (wr_presc_c) begin
         prescale_n = dma_io_wdata[PW-1:0];
      end
      if (start_c) begin
         pcnt_n = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale_q <= '0;
         pcnt_q     <= '0;
      end else begin
         prescale_q <= prescale_n;
         pcnt_q     <= pcnt_n;
      end
   end
`else
   assign tick_c        = en_q;
   assign prescale_rd_c = '0;
`endif

   // Register next-state; later assignments carry higher priority
   always_comb begin
      en_n     = en_q;
      auto_n   = auto_q;
      ie_n     = ie_q;
      pend_n   = pend_q;
      reload_n = reload_q;
      count_n  = count_q;

      if (wr_status_c && dma_io_wdata[0]) begin
         pend_n = 1'b0;
      end

      if (tick_c) begin
         if (!expire_c) begin
            count_n = count_q - DW'(1);
         end else begin
            pend_n = 1'b1;
            if (auto_q) begin
               count_n = reload_q;
            end else begin
               en_n    = 1'b0;
               count_n = '0;
            end
         end
      end

      if (wr_reload_c) begin
         reload_n = dma_io_wdata;
      end

      if (wr_ctrl_c) begin
         en_n   = dma_io_wdata[0];
         auto_n = dma_io_wdata[1];
         ie_n   = dma_io_wdata[2];
      end

      if (start_c) begin
         count_n = reload_q;
      end

      if (wr_count_c) begin
         count_n = dma_io_wdata;
      end
   end

   // Read decode, registered one cycle later
   always_comb begin
      rd_hit_c = 1'b1;
      rd_val_c = '0;
      case (dma_io_radr)
         ADR_CTRL:   rd_val_c = {13'b0, ie_q, auto_q, en_q};
         ADR_PRESC:  rd_val_c = {8'b0, prescale_rd_c};
         ADR_RELOAD: rd_val_c = reload_q;
         ADR_COUNT:  rd_val_c = count_q;
         ADR_STATUS: rd_val_c = {15'b0, pend_q};
         default:    rd_hit_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q        <= 1'b0;
         auto_q      <= 1'b0;
         ie_q        <= 1'b0;
         pend_q      <= 1'b0;
         reload_q    <= '0;
         count_q     <= '0;
         hit_q       <= 1'b0;
         rdata_q     <= '0;
         interrupt_0 <= 1'b0;
      end else begin
         en_q        <= en_n;
         auto_q      <= auto_n;
         ie_q        <= ie_n;
         pend_q      <= pend_n;
         reload_q    <= reload_n;
         count_q     <= count_n;
         hit_q       <= rd_hit_c;
         rdata_q     <= rd_val_c;
         interrupt_0 <= pend_q & ie_q;
      end
   end

   // Daisy chain: pass upstream data through unless this block was addressed
   assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;

endmodule

// File: tb/tb_io_timer.sv
// Scoreboard bench for io_timer: per-cycle expectations from a behavioural model, plus fixed values for directed scenarios.
module tb_io_timer;

   localparam logic [13:0] B = 14'h3C00;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [15:2] wadr;
   logic [15:0] wdata;
   logic [15:2] radr;
   logic [15:0] rin;
   logic [15:0] rdata;
   logic        irq;

   always #5 clk = ~clk;

   io_timer #(.BASE(B)) dut (
      .clk             (clk),
      .rst             (rst),
      .dma_io_we       (we),
      .dma_io_wadr     (wadr),
      .dma_io_wdata    (wdata),
      .dma_io_radr     (radr),
      .dma_io_rdata_in (rin),
      .dma_io_rdata    (rdata),
      .interrupt_0     (irq)
   );

   typedef struct {
      logic [15:0] rd;
      logic        irq;
      bit          kr;
      logic [15:0] krd;
      bit          ki;
      logic        kirq;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_no = 0;

   // Reference model: software-visible timer state
   bit          m_en, m_auto, m_ie, m_pend;
   logic [15:0] m_reload, m_count;
   logic [7:0]  m_presc;
`ifdef IO_TIMER_PRESCALE_EN
   logic [7:0]  m_phase;
`endif

   bit          kr_next = 0;
   logic [15:0] krd_next = '0;
   bit          ki_next = 0;
   logic        kirq_next = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp, input int c);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %h, required %h", name, c, act, exp);
      end
   endtask

   function automatic bit m_read(input logic [13:0] a, output logic [15:0] v);
      logic [13:0] off;
      off = a - B;
      v = '0;
      if (off > 14'd4) return 1'b0;
      case (off)
         14'd0:   v = {13'b0, m_ie, m_auto, m_en};
         14'd1:   v = {8'b0, m_presc};
         14'd2:   v = m_reload;
         14'd3:   v = m_count;
         default: v = {15'b0, m_pend};
      endcase
      return 1'b1;
   endfunction

   // One clock of timer behaviour: what software wrote, and whether the prescaled tick fired
   task automatic model_step(input bit r, input bit w, input logic [13:0] wa, input logic [15:0] wd);
      logic [13:0] off;
      bit hit, tick, expire, start;
      if (r) begin
         {m_en, m_auto, m_ie, m_pend} = '0;
         m_reload = '0; m_count = '0; m_presc = '0;
`ifdef IO_TIMER_PRESCALE_EN
         m_phase = '0;
`endif
         return;
      end
      off = wa - B;
      hit = w && (off <= 14'd4);
`ifdef IO_TIMER_PRESCALE_EN
      tick = m_en && (m_phase == m_presc);
      if (m_en) m_phase = tick ? 8'd0 : m_phase + 8'd1;
`else
      tick = m_en;
`endif
      expire = tick && (m_count == 16'd0);
      start  = hit && off == 14'd0 && wd[0] && !m_en;

      if (expire) m_pend = 1'b1;
      else if (hit && off == 14'd4 && wd[0]) m_pend = 1'b0;

      if (hit && off == 14'd3) m_count = wd;
      else if (start)          m_count = m_reload;
      else if (expire)         m_count = m_auto ? m_reload : 16'd0;
      else if (tick)           m_count = m_count - 16'd1;

      if (hit && off == 14'd0) {m_ie, m_auto, m_en} = wd[2:0];
      else if (expire && !m_auto) m_en = 1'b0;

      if (hit && off == 14'd2) m_reload = wd;
`ifdef IO_TIMER_PRESCALE_EN
      if (hit && off == 14'd1) m_presc = wd[7:0];
      if (start) m_phase = 8'd0;
`endif
   endtask

   task automatic cyc(input bit r, input bit w, input logic [13:0] wa, input logic [15:0] wd,
                      input logic [13:0] ra, input logic [15:0] ri);
      exp_t e;
      logic [15:0] v;
      bit h;
      @(negedge clk);
      rst = r; we = w; wadr = wa; wdata = wd; radr = ra; rin = ri;
      h = m_read(ra, v);
      e.rd   = (r || !h) ? ri : v;
      e.irq  = r ? 1'b0 : (m_pend & m_ie);
      e.kr   = kr_next;  e.krd  = krd_next;
      e.ki   = ki_next;  e.kirq = kirq_next;
      e.cyc  = cyc_no++;
      kr_next = 0; ki_next = 0;
      sbq.push_back(e);
      model_step(r, w, wa, wd);
   endtask

   task automatic expect_rd(input logic [15:0] v);
      kr_next = 1; krd_next = v;
   endtask

   task automatic expect_irq(input logic v);
      ki_next = 1; kirq_next = v;
   endtask

   task automatic wr(input int off, input logic [15:0] v);
      cyc(0, 1, B + 14'(off), v, B + 14'd7, 16'($urandom));
   endtask

   task automatic rd(input int off);
      cyc(0, 0, B + 14'd6, 16'h0, B + 14'(off), 16'($urandom));
   endtask

   // Monitor: compare every cycle the DUT presents registered outputs
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("rdata", rdata, e.rd, e.cyc);
            check("interrupt_0", {15'b0, irq}, {15'b0, e.irq}, e.cyc);
            if (e.kr) check("fixed_rdata", rdata, e.krd, e.cyc);
            if (e.ki) check("fixed_irq", {15'b0, irq}, {15'b0, e.kirq}, e.cyc);
         end
      end
   end

   initial begin
      rst = 1'b1; we = 1'b0; wadr = '0; wdata = '0; radr = '0; rin = '0;
      model_step(1, 0, '0, '0);
      repeat (3) cyc(1, 0, '0, '0, B + 14'd7, 16'($urandom));

      // Reset state of every register
      for (int i = 0; i < 5; i++) begin
         expect_rd(16'h0000);
         if (i == 0) expect_irq(1'b0);
         rd(i);
      end

      // Basic count with W1C on the expiry cycle
      wr(1, 16'h0000); wr(2, 16'h0003); wr(0, 16'h0005);
      expect_rd(16'd3); rd(3);
      expect_rd(16'd2); rd(3);
      expect_rd(16'd1); rd(3);
      expect_rd(16'd0); expect_irq(1'b0);
      cyc(0, 1, B + 14'd4, 16'h0001, B + 14'd3, 16'($urandom));
      expect_rd(16'd1); expect_irq(1'b1); rd(4);
      expect_rd(16'h0004); rd(0);
      wr(4, 16'h0001); wr(0, 16'h0000);

`ifdef IO_TIMER_PRESCALE_EN
      // Auto-reload with prescale 4, reload 2: expiry every 15 cycles
      wr(1, 16'h0004); wr(2, 16'h0002); wr(0, 16'h0003);
      for (int k = 1; k <= 46; k++) begin
         if (k > 1 && (k % 15) == 1) begin
            expect_rd(16'd1);
            cyc(0, 1, B + 14'd4, 16'h0001, B + 14'd4, 16'($urandom));
         end else begin
            expect_rd(16'd0);
            rd(4);
         end
      end
      wr(0, 16'h0000); wr(4, 16'h0001); wr(1, 16'h0000);
`else
      // No prescaler: PRESCALE ignored, expiry two cycles after enable
      wr(1, 16'h00FF); wr(2, 16'h0001); wr(0, 16'h0001);
      for (int k = 1; k <= 3; k++) begin
         expect_rd((k == 3) ? 16'd1 : 16'd0);
         rd(4);
      end
      expect_rd(16'h0000); rd(1);
      wr(4, 16'h0001);
`endif

      // Read chaining
      wr(2, 16'hA5A5);
      expect_rd(16'hA5A5); rd(2);
      expect_rd(16'h1234); cyc(0, 0, B + 14'd6, 16'h0, B + 14'd7, 16'h1234);

      // Reload 0 with auto: expiry on every tick, then reset mid-count with interrupt high
      wr(1, 16'h0000); wr(2, 16'h0000); wr(0, 16'h0007);
      repeat (4) rd(4);
      wr(2, 16'h0100);
      expect_irq(1'b1); wr(3, 16'h0100);
      cyc(1, 0, '0, '0, B + 14'd3, 16'h5A5A);
      #1;
      check("async_irq", {15'b0, irq}, 16'h0000, cyc_no);
      check("async_rdata", rdata, 16'h5A5A, cyc_no);
      cyc(1, 0, '0, '0, B + 14'd3, 16'($urandom));
      for (int i = 0; i < 5; i++) begin
         expect_rd(16'h0000); rd(i);
      end
      for (int k = 0; k < 20; k++) begin
         expect_rd(16'h0000); expect_irq(1'b0); rd(4);
      end

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit          r, w;
         logic [13:0] wa, ra;
         logic [15:0] wd;
         r  = ($urandom_range(0, 399) == 0);
         w  = ($urandom_range(0, 3) == 0);
         wa = B + 14'($urandom_range(0, 5));
         wd = 16'($urandom);
         if (wa == B + 14'd1) wd = 16'($urandom_range(0, 5));
         if ((wa == B + 14'd2 || wa == B + 14'd3) && $urandom_range(0, 1) == 1) wd = wd & 16'h001F;
         ra = ($urandom_range(0, 9) == 0) ? 14'($urandom) : B + 14'($urandom_range(0, 7));
         cyc(r, w, wa, wd, ra, 16'($urandom));
      end
      cyc(0, 0, B + 14'd6, '0, B + 14'd7, '0);

      for (int t = 0; t < 10 && sbq.size() > 0; t++) @(posedge clk);
      #2;
      check("scoreboard_drained", 16'(sbq.size()), 16'h0000, cyc_no);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
